sevenseg_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment digits. It generalises the single-digit hex decoder to `NUM_DIGITS` digits, for example to display a full 32-bit word received over UART on eight digits. Per-digit features:
- anode scanning with anti-ghosting dead time
- blanking and decimal-point control
- optional leading-zero suppression
- tear-free value updates committed at frame boundaries

---
 rtl/sevenseg_pkg.sv | 20 ++
 rtl/sevenseg_hex_font_decode.sv | 17 +
 rtl/sevenseg_scan_driver.sv | 188 ++++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Contents:
//   seg_t     - seven-segment pattern, ordered {a,b,c,d,e,f,g} from MSB to LSB
//   SEG_OFF   - active-low pattern with every segment dark
//   HEX_FONT  - active-high 0..F hex font, indexed by nibble value
package sevenseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'h7F;

   // Active-high glyphs; the decoder inverts them for the common-anode bank.
   localparam seg_t HEX_FONT [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79,
      7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F,
      7'h4E, 7'h3D, 7'h4F, 7'h47
   };

endpackage

// File: rtl/sevenseg_hex_font_decode.sv
// Combinational hex-to-seven-segment decoder.
// Ports:
//   nibble   - 4-bit value to display
//   segments - active-low segment pattern {a,b,c,d,e,f,g}
module hex_font_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   // The package font is active-high; the display is common-anode, so invert.
   always_comb begin
      segments = ~HEX_FONT[nibble];
   end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Each digit owns a slot of REFRESH_DIV cycles; the first GHOST_CYCLES of a
// slot keep every anode off so the previous digit's pattern cannot ghost.
// New values are captured on 'load' and only committed to the display at the
// frame wrap, so a frame never shows a mixture of old and new digits.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   value_in    - nibble i is shown on digit i (digit 0 rightmost)
//   blank_in    - per-digit force-dark
//   dp_in       - per-digit decimal point enable
//   lzs_en      - leading-zero suppression enable
//   load        - strobe capturing value_in/blank_in/dp_in/lzs_en
//   pending     - a captured value is waiting for the frame wrap
//   frame_tick  - one-cycle pulse in the cycle after each frame wrap
//   anodes      - active-low digit enables
//   segments    - active-low segments {a,b,c,d,e,f,g}
//   dp_n        - active-low decimal point
module sevenseg_scan_driver
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int GHOST_CYCLES = 1000
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lzs_en,
   input  logic                    load,
   output logic                    pending,
   output logic                    frame_tick,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic [6:0]              segments,
   output logic                    dp_n
);

   localparam int SLOT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0] GHOST_END = SLOT_W'(GHOST_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   // Reject parameter sets the counters and anode decode cannot represent.
   if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
      $error("sevenseg_scan_driver: NUM_DIGITS must be in 1..16");
   end
   if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("sevenseg_scan_driver: REFRESH_DIV must be at least 2");
   end
   if (GHOST_CYCLES < 0 || GHOST_CYCLES >= REFRESH_DIV) begin : g_bad_ghost
      $error("sevenseg_scan_driver: GHOST_CYCLES must be below REFRESH_DIV");
   end

   logic [SLOT_W-1:0]       slot_cnt;
   logic [IDX_W-1:0]        digit_idx;
   logic                    slot_end;
   logic                    commit;

   logic [4*NUM_DIGITS-1:0] pending_value;
   logic [NUM_DIGITS-1:0]   pending_blank;
   logic [NUM_DIGITS-1:0]   pending_dp;
   logic                    pending_lzs;

   logic [4*NUM_DIGITS-1:0] display_value;
   logic [NUM_DIGITS-1:0]   display_blank;
   logic [NUM_DIGITS-1:0]   display_dp;
   logic                    display_lzs;

   logic [NUM_DIGITS-1:0]   suppress;
   logic                    zero_run;
   logic [3:0]              cur_nibble;
   logic                    cur_dark;
   logic                    cur_dp;
   logic [6:0]              font_seg;
   logic [NUM_DIGITS-1:0]   anode_next;

   assign slot_end = (slot_cnt == SLOT_LAST);
   assign commit   = slot_end && (digit_idx == IDX_LAST);

   // Slot counter and digit index; the digit advances on the last slot cycle
   // and the wrap back to digit 0 is the commit point.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else if (slot_end) begin
         slot_cnt  <= '0;
         digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
         slot_cnt  <= slot_cnt + 1'b1;
      end
   end

   // Pending and display registers. A load landing exactly on the commit point
   // goes straight to the display so it is not delayed by a whole frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending       <= 1'b0;
         pending_value <= '0;
         pending_blank <= '0;
         pending_dp    <= '0;
         pending_lzs   <= 1'b0;
         display_value <= '0;
         display_blank <= '0;
         display_dp    <= '0;
         display_lzs   <= 1'b0;
      end else if (commit && load) begin
         pending       <= 1'b0;
         display_value <= value_in;
         display_blank <= blank_in;
         display_dp    <= dp_in;
         display_lzs   <= lzs_en;
      end else if (commit && pending) begin
         pending       <= 1'b0;
         display_value <= pending_value;
         display_blank <= pending_blank;
         display_dp    <= pending_dp;
         display_lzs   <= pending_lzs;
      end else if (load) begin
         pending       <= 1'b1;
         pending_value <= value_in;
         pending_blank <= blank_in;
         pending_dp    <= dp_in;
         pending_lzs   <= lzs_en;
      end
   end

   // Leading-zero mask: walk down from the top digit while every nibble seen
   // so far is zero. Digit 0 is never suppressed so a zero value still shows.
   always_comb begin
      zero_run = 1'b1;
      suppress = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run    = zero_run & (display_value[4*i +: 4] == 4'h0);
         suppress[i] = display_lzs & zero_run;
      end
   end

   // Select the attributes of the digit currently being scanned.
   always_comb begin
      cur_nibble = 4'h0;
      cur_dark   = 1'b0;
      cur_dp     = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            cur_nibble = display_value[4*i +: 4];
            cur_dark   = display_blank[i] | suppress[i];
            cur_dp     = display_dp[i];
         end
      end
   end

   hex_font_decode u_font (
      .nibble   (cur_nibble),
      .segments (font_seg)
   );

   // Only the scanned digit's anode is pulled low, and only once the
   // dead-time window at the start of its slot has elapsed.
   always_comb begin
      anode_next = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i) && slot_cnt >= GHOST_END) begin
            anode_next[i] = 1'b0;
         end
      end
   end

   // Registered outputs so the pins never glitch while the mux settles.
   always_ff @(posedge clk) begin
      if (rst) begin
         anodes     <= '1;
         segments   <= SEG_OFF;
         dp_n       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         anodes     <= anode_next;
         segments   <= cur_dark ? SEG_OFF : font_seg;
         dp_n       <= ~cur_dp;
         frame_tick <= commit;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomised scoreboard bench for sevenseg_scan_driver (4 digits, 8-cycle
// slots, 2 dead-time cycles). The driver predicts the registered outputs from
// a frame-position model and queues them; the monitor checks each prediction
// one step after the clock edge it belongs to.
module tb_sevenseg_scan_driver;

   localparam int N     = 4;
   localparam int R     = 8;
   localparam int G     = 2;
   localparam int FRAME = N * R;

   localparam logic [6:0] FONT [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value_in;
   logic [3:0]  blank_in;
   logic [3:0]  dp_in;
   logic        lzs_en;
   logic        load;
   logic        pending;
   logic        frame_tick;
   logic [3:0]  anodes;
   logic [6:0]  segments;
   logic        dp_n;

   sevenseg_scan_driver #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (R),
      .GHOST_CYCLES (G)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value_in   (value_in),
      .blank_in   (blank_in),
      .dp_in      (dp_in),
      .lzs_en     (lzs_en),
      .load       (load),
      .pending    (pending),
      .frame_tick (frame_tick),
      .anodes     (anodes),
      .segments   (segments),
      .dp_n       (dp_n)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       tick;
      logic       pend;
   } exp_t;

   exp_t exp_q[$];

   int tests_run    = 0;
   int tests_failed = 0;

   // Behavioural model: position within the frame plus the committed and
   // waiting display contents.
   int          m_t;
   logic [15:0] m_disp_value, m_pend_value;
   logic [3:0]  m_disp_blank, m_pend_blank, m_disp_dp, m_pend_dp;
   logic        m_disp_lzs, m_pend_lzs, m_pending;

   // A digit is dark when blanked, or when suppression is on and it and all
   // higher digits are zero (digit 0 always shows).
   function automatic logic digit_dark(input int d);
      logic [3:0] nib;
      if (m_disp_blank[d]) return 1'b1;
      if (d == 0 || !m_disp_lzs) return 1'b0;
      for (int j = d; j < N; j++) begin
         nib = m_disp_value[4*j +: 4];
         if (nib != 4'h0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] b,
                                input logic [3:0] d, input logic lz, input logic r);
      exp_t e;
      int   slot;
      int   dig;
      logic commit;
      @(negedge clk);
      rst      = r;
      load     = ld;
      value_in = v;
      blank_in = b;
      dp_in    = d;
      lzs_en   = lz;
      if (r) begin
         m_t = 0;
         m_disp_value = '0; m_disp_blank = '0; m_disp_dp = '0; m_disp_lzs = 1'b0;
         m_pend_value = '0; m_pend_blank = '0; m_pend_dp = '0; m_pend_lzs = 1'b0;
         m_pending = 1'b0;
         e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0; e.pend = 1'b0;
      end else begin
         slot   = m_t % R;
         dig    = m_t / R;
         commit = (m_t == FRAME - 1);
         e.an   = (slot >= G) ? ~(4'b0001 << dig) : 4'hF;
         e.seg  = digit_dark(dig) ? 7'h7F : ~FONT[m_disp_value[4*dig +: 4]];
         e.dp   = ~m_disp_dp[dig];
         e.tick = commit;
         if (commit && ld) begin
            m_disp_value = v; m_disp_blank = b; m_disp_dp = d; m_disp_lzs = lz;
            m_pending = 1'b0;
         end else if (commit && m_pending) begin
            m_disp_value = m_pend_value; m_disp_blank = m_pend_blank;
            m_disp_dp = m_pend_dp; m_disp_lzs = m_pend_lzs;
            m_pending = 1'b0;
         end else if (ld) begin
            m_pend_value = v; m_pend_blank = b; m_pend_dp = d; m_pend_lzs = lz;
            m_pending = 1'b1;
         end
         e.pend = m_pending;
         m_t = (m_t + 1) % FRAME;
      end
      exp_q.push_back(e);
   endtask

   // Idle cycles still toggle the data inputs so ignored-unless-loaded is tested.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      end
   endtask

   task automatic waitForT(input int target);
      for (int i = 0; i < FRAME && m_t != target; i++) begin
         idle(1);
      end
   endtask

   // Monitor: outputs are registered, so sample just after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("anodes",     16'(anodes),     16'(e.an));
         checkOutput("segments",   16'(segments),   16'(e.seg));
         checkOutput("dp_n",       16'(dp_n),       16'(e.dp));
         checkOutput("frame_tick", 16'(frame_tick), 16'(e.tick));
         checkOutput("pending",    16'(pending),    16'(e.pend));
      end
   end

   initial begin
      rst = 1'b1; load = 1'b0; value_in = '0; blank_in = '0; dp_in = '0; lzs_en = 1'b0;
      m_t = 0; m_pending = 1'b0;

      // Reset, then zeros until the first load commits.
      applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      idle(10);
      applyStimulus(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0, 1'b0);
      idle(2 * FRAME);

      // Leading-zero suppression on and off.
      applyStimulus(1'b1, 16'h0005, 4'h0, 4'h0, 1'b1, 1'b0);
      idle(2 * FRAME);
      applyStimulus(1'b1, 16'h0005, 4'h0, 4'h0, 1'b0, 1'b0);
      idle(2 * FRAME);

      // Two loads before one wrap: only the second may appear.
      waitForT(10);
      applyStimulus(1'b1, 16'hAAAA, 4'h0, 4'h0, 1'b0, 1'b0);
      idle(5);
      applyStimulus(1'b1, 16'hB3C7, 4'h0, 4'h0, 1'b0, 1'b0);
      idle(2 * FRAME);

      // Load on the commit cycle itself bypasses the pending stage.
      waitForT(FRAME - 1);
      applyStimulus(1'b1, 16'h6E8D, 4'h0, 4'h0, 1'b0, 1'b0);
      idle(FRAME);

      // Blank with decimal point on digit 2.
      applyStimulus(1'b1, 16'h4321, 4'b0100, 4'b0100, 1'b0, 1'b0);
      idle(2 * FRAME);

      // Reset mid-slot with a value waiting; it must never appear.
      waitForT(12);
      applyStimulus(1'b1, 16'h9999, 4'h0, 4'hF, 1'b0, 1'b0);
      idle(1);
      applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      idle(2 * FRAME + 5);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 15) == 0),
                       (($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom)),
                       (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0),
                       4'($urandom), 1'($urandom),
                       ($urandom_range(0, 499) == 0));
      end

      // Let the monitor consume the remaining predictions.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
